// File: rtl/mlaccel_pkg.sv
// Shared widths, owner tags and round-robin encodings for the
// main-memory arbiter slice.
package mlaccel_pkg;

  localparam int MLACCEL_ADDR_W = 16;
  localparam int MLACCEL_DATA_W = 64;

  localparam int Q_LANE_W = 16;
  localparam int S_LANE_W = 32;
  localparam int C_LANE_W = 64;

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_C    = 2'd1;
  localparam logic [1:0] TAG_Q    = 2'd2;
  localparam logic [1:0] TAG_S    = 2'd3;

  localparam logic LAST_Q = 1'b0;
  localparam logic LAST_S = 1'b1;

endpackage

// File: rtl/mlaccel_satcnt.sv
// 16-bit saturating counter with synchronous clear.
// Clear wins over increment in the same cycle.
module mlaccel_satcnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] cnt
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = 16'h0000;
    else if (inc && (cnt_q != 16'hFFFF))
      cnt_d = cnt_q + 16'h0001;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= 16'h0000;
    else
      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mlaccel_memarb.sv
// Compute-first, host/fetch round-robin arbiter for main memory.
// Stall counters exist only with MLACCEL_MEMARB_PERF_EN defined.
module mlaccel_memarb
  import mlaccel_pkg::*;
#(
  parameter int ADDR_W = MLACCEL_ADDR_W,
  parameter int DATA_W = MLACCEL_DATA_W
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                c_req,
  input  logic [DATA_W/8-1:0] c_wen,
  input  logic [ADDR_W-1:0]   c_addr,
  input  logic [DATA_W-1:0]   c_wdata,
  output logic                c_rvalid,
  output logic [C_LANE_W-1:0] c_rdata,
  input  logic                q_req,
  input  logic [1:0]          q_wen,
  input  logic [ADDR_W-1:0]   q_addr,
  input  logic [Q_LANE_W-1:0] q_wdata,
  output logic                q_gnt,
  output logic                q_rvalid,
  output logic [Q_LANE_W-1:0] q_rdata,
  input  logic                s_req,
  input  logic [ADDR_W-1:0]   s_addr,
  output logic                s_gnt,
  output logic                s_rvalid,
  output logic [S_LANE_W-1:0] s_rdata,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W/8-1:0] m_wen,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                perf_clear,
  output logic [15:0]         q_stall_cnt,
  output logic [15:0]         s_stall_cnt
);

  logic       c_act;
  logic       q_win;
  logic       s_win;
  logic       last_q;
  logic       last_d;
  logic [1:0] tag_q;
  logic [1:0] tag_d;

  assign c_act = c_req | (|c_wen);

  // Tie goes to whichever of host/fetch was not served last.
  always_comb begin
    q_win = 1'b0;
    s_win = 1'b0;
    if (!c_act) begin
      q_win = q_req && (!s_req || (last_q == LAST_S));
      s_win = s_req && !q_win;
    end
  end

  assign q_gnt = q_win;
  assign s_gnt = s_win;

  always_comb begin
    m_addr  = c_addr;
    m_wen   = '0;
    m_wdata = c_wdata;
    tag_d   = TAG_NONE;
    last_d  = last_q;
    unique case (1'b1)
      c_act: begin
        m_wen = c_wen;
        if (c_wen == '0)
          tag_d = TAG_C;
      end
      q_win: begin
        m_addr  = q_addr;
        m_wen   = {{(DATA_W/8-2){1'b0}}, q_wen};
        m_wdata = {{(DATA_W-Q_LANE_W){1'b0}}, q_wdata};
        last_d  = LAST_Q;
        if (q_wen == 2'b00)
          tag_d = TAG_Q;
      end
      s_win: begin
        m_addr  = s_addr;
        m_wdata = '0;
        last_d  = LAST_S;
        tag_d   = TAG_S;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      last_q <= LAST_S;
      tag_q  <= TAG_NONE;
    end else begin
      last_q <= last_d;
      tag_q  <= tag_d;
    end
  end

  assign c_rvalid = (tag_q == TAG_C);
  assign q_rvalid = (tag_q == TAG_Q);
  assign s_rvalid = (tag_q == TAG_S);

  assign c_rdata = m_rdata[C_LANE_W-1:0];
  assign q_rdata = m_rdata[Q_LANE_W-1:0];
  assign s_rdata = m_rdata[S_LANE_W-1:0];

`ifdef MLACCEL_MEMARB_PERF_EN
  mlaccel_satcnt u_q_stall (
    .clk   (clock),
    .rst_n (resetn),
    .clr   (perf_clear),
    .inc   (q_req && !q_win),
    .cnt   (q_stall_cnt)
  );

  mlaccel_satcnt u_s_stall (
    .clk   (clock),
    .rst_n (resetn),
    .clr   (perf_clear),
    .inc   (s_req && !s_win),
    .cnt   (s_stall_cnt)
  );
`else
  logic unused_perf_clear;
  assign unused_perf_clear = perf_clear;
  assign q_stall_cnt = 16'h0000;
  assign s_stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mlaccel_memarb.sv
// Directed bench for mlaccel_memarb with a behavioural
// single-port memory; long counter test only with MLACCEL_MEMARB_PERF_EN.
module tb_mlaccel_memarb;

  logic        clock;
  logic        resetn;
  logic        c_req;
  logic [7:0]  c_wen;
  logic [15:0] c_addr;
  logic [63:0] c_wdata;
  logic        c_rvalid;
  logic [63:0] c_rdata;
  logic        q_req;
  logic [1:0]  q_wen;
  logic [15:0] q_addr;
  logic [15:0] q_wdata;
  logic        q_gnt;
  logic        q_rvalid;
  logic [15:0] q_rdata;
  logic        s_req;
  logic [15:0] s_addr;
  logic        s_gnt;
  logic        s_rvalid;
  logic [31:0] s_rdata;
  logic [15:0] m_addr;
  logic [7:0]  m_wen;
  logic [63:0] m_wdata;
  logic [63:0] m_rdata;
  logic        perf_clear;
  logic [15:0] q_stall_cnt;
  logic [15:0] s_stall_cnt;

  int checks;
  int failures;
  int wr10_cnt;
  int qg_total;
  logic exp_q;
  logic prev_q;

  logic [63:0] mem [0:65535];

  mlaccel_memarb dut (
    .clock       (clock),
    .resetn      (resetn),
    .c_req       (c_req),
    .c_wen       (c_wen),
    .c_addr      (c_addr),
    .c_wdata     (c_wdata),
    .c_rvalid    (c_rvalid),
    .c_rdata     (c_rdata),
    .q_req       (q_req),
    .q_wen       (q_wen),
    .q_addr      (q_addr),
    .q_wdata     (q_wdata),
    .q_gnt       (q_gnt),
    .q_rvalid    (q_rvalid),
    .q_rdata     (q_rdata),
    .s_req       (s_req),
    .s_addr      (s_addr),
    .s_gnt       (s_gnt),
    .s_rvalid    (s_rvalid),
    .s_rdata     (s_rdata),
    .m_addr      (m_addr),
    .m_wen       (m_wen),
    .m_wdata     (m_wdata),
    .m_rdata     (m_rdata),
    .perf_clear  (perf_clear),
    .q_stall_cnt (q_stall_cnt),
    .s_stall_cnt (s_stall_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Byte-enabled memory, read data one cycle after the address.
  always @(posedge clock) begin
    m_rdata <= mem[m_addr];
    for (int b = 0; b < 8; b++)
      if (m_wen[b])
        mem[m_addr][b*8 +: 8] <= m_wdata[b*8 +: 8];
    if (m_wen != 8'h00 && m_addr == 16'h0010)
      wr10_cnt <= wr10_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs change.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    wr10_cnt = 0;
    qg_total = 0;
    for (int i = 0; i < 65536; i++)
      mem[i] = 64'h0;
    mem[16'h1234] = 64'h1111_2222_3333_0000;
    mem[16'h0040] = 64'h0123_4567_89AB_CDEF;
    m_rdata    = 64'h0;
    resetn     = 1'b0;
    c_req      = 1'b1;
    c_wen      = 8'h00;
    c_addr     = 16'h0000;
    c_wdata    = 64'h0;
    q_req      = 1'b1;
    q_wen      = 2'b00;
    q_addr     = 16'h0000;
    q_wdata    = 16'h0;
    s_req      = 1'b1;
    s_addr     = 16'h0000;
    perf_clear = 1'b0;

    // Reset held with all requests active
    step();
    step();
    settle();
    check("rst_c_rvalid", c_rvalid, 1'b0);
    check("rst_q_rvalid", q_rvalid, 1'b0);
    check("rst_s_rvalid", s_rvalid, 1'b0);
    check("rst_m_wen", m_wen, 8'h00);
    check("rst_q_stall", q_stall_cnt, 16'h0);
    check("rst_s_stall", s_stall_cnt, 16'h0);

    // Release: first tie goes to host
    step();
    resetn = 1'b1;
    c_req  = 1'b0;
    settle();
    check("tie1_q_gnt", q_gnt, 1'b1);
    check("tie1_s_gnt", s_gnt, 1'b0);
    step();
    q_req = 1'b0;
    settle();
    check("tie2_s_gnt", s_gnt, 1'b1);
    check("tie2_q_rvalid", q_rvalid, 1'b1);
    step();
    s_req = 1'b0;
    settle();
    check("tie3_s_rvalid", s_rvalid, 1'b1);
    check("tie3_q_rvalid", q_rvalid, 1'b0);

    // Compute writes override both requesters
    q_req  = 1'b1;
    s_req  = 1'b1;
    c_wen  = 8'hFF;
    c_addr = 16'h0010;
    for (int i = 0; i < 3; i++) begin
      c_wdata = 64'hA5A5_0000_0000_0000 + 64'(i);
      settle();
      check("cpri_q_gnt", q_gnt, 1'b0);
      check("cpri_s_gnt", s_gnt, 1'b0);
      check("cpri_m_wen", m_wen, 8'hFF);
      check("cpri_m_addr", m_addr, 16'h0010);
      step();
    end
    c_wen = 8'h00;
    settle();
    check("cpri_c_rvalid", c_rvalid, 1'b0);
    check("cpri_writes", wr10_cnt, 3);
    check("cpri_mem", mem[16'h0010], 64'hA5A5_0000_0000_0002);
    check("cpri_q_after", q_gnt, 1'b1);
    check("cpri_s_after", s_gnt, 1'b0);
    step();
    q_req = 1'b0;
    settle();
    check("cpri_s_next", s_gnt, 1'b1);
    step();
    s_req = 1'b0;

    // Host write then readback
    q_req   = 1'b1;
    q_wen   = 2'b11;
    q_addr  = 16'h1234;
    q_wdata = 16'hBEEF;
    settle();
    check("hw_q_gnt", q_gnt, 1'b1);
    check("hw_m_wen", m_wen, 8'h03);
    check("hw_m_wdata", m_wdata, 64'h0000_0000_0000_BEEF);
    check("hw_m_addr", m_addr, 16'h1234);
    step();
    q_wen = 2'b00;
    settle();
    check("hr_q_gnt", q_gnt, 1'b1);
    check("hw_no_rvalid", q_rvalid, 1'b0);
    step();
    q_req = 1'b0;
    settle();
    check("hr_q_rvalid", q_rvalid, 1'b1);
    check("hr_q_rdata", q_rdata, 16'hBEEF);
    check("hr_c_rvalid", c_rvalid, 1'b0);
    check("hr_upper", mem[16'h1234][63:16], 48'h1111_2222_3333);
    step();
    settle();
    check("hr_q_rvalid_off", q_rvalid, 1'b0);

    // Fetch read
    s_req  = 1'b1;
    s_addr = 16'h0040;
    settle();
    check("fr_s_gnt", s_gnt, 1'b1);
    check("fr_m_addr", m_addr, 16'h0040);
    check("fr_m_wen", m_wen, 8'h00);
    step();
    s_req = 1'b0;
    settle();
    check("fr_s_rvalid", s_rvalid, 1'b1);
    check("fr_s_rdata", s_rdata, 32'h89AB_CDEF);
    check("fr_c_rvalid", c_rvalid, 1'b0);
    check("fr_q_rvalid", q_rvalid, 1'b0);

    // Compute read
    c_req  = 1'b1;
    c_addr = 16'h0040;
    step();
    c_req = 1'b0;
    settle();
    check("cr_c_rvalid", c_rvalid, 1'b1);
    check("cr_c_rdata", c_rdata, 64'h0123_4567_89AB_CDEF);
    check("cr_s_rvalid", s_rvalid, 1'b0);

    // Round robin: last served was fetch, so host goes first
    q_req  = 1'b1;
    s_req  = 1'b1;
    q_addr = 16'h1234;
    exp_q  = 1'b1;
    prev_q = 1'b0;
    for (int i = 0; i < 8; i++) begin
      settle();
      check("rr_q_gnt", q_gnt, exp_q);
      check("rr_s_gnt", s_gnt, !exp_q);
      if (q_gnt)
        qg_total++;
      if (i > 0)
        check("rr_owner_q", q_rvalid, prev_q);
      prev_q = exp_q;
      exp_q  = !exp_q;
      step();
    end
    q_req = 1'b0;
    s_req = 1'b0;
    settle();
    check("rr_owner_last_s", s_rvalid, !prev_q);
    check("rr_q_total", qg_total, 4);

    // Reset during a pending read drops the return
    step();
    q_req = 1'b1;
    settle();
    check("rm_q_gnt", q_gnt, 1'b1);
    resetn = 1'b0;
    step();
    q_req = 1'b0;
    settle();
    check("rm_q_rvalid", q_rvalid, 1'b0);
    step();
    resetn = 1'b1;

`ifdef MLACCEL_MEMARB_PERF_EN
    c_req = 1'b1;
    q_req = 1'b1;
    step();
    step();
    step();
    settle();
    check("pc_q_small", q_stall_cnt, 16'd3);
    check("pc_s_small", s_stall_cnt, 16'd0);
    repeat (70000) @(posedge clock);
    #3;
    check("pc_q_sat", q_stall_cnt, 16'hFFFF);
    check("pc_s_idle", s_stall_cnt, 16'h0);
    perf_clear = 1'b1;
    step();
    perf_clear = 1'b0;
    settle();
    check("pc_q_clear", q_stall_cnt, 16'h0);
    step();
    settle();
    check("pc_q_resume", q_stall_cnt, 16'd1);
    c_req = 1'b0;
    q_req = 1'b0;
`else
    c_req = 1'b1;
    q_req = 1'b1;
    s_req = 1'b1;
    perf_clear = 1'b1;
    step();
    perf_clear = 1'b0;
    step();
    step();
    settle();
    check("pc_off_q", q_stall_cnt, 16'h0);
    check("pc_off_s", s_stall_cnt, 16'h0);
    c_req = 1'b0;
    q_req = 1'b0;
    s_req = 1'b0;
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
